// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one add/multiply ALU among NREQ requesters
module alu_share_arbiter #(
    parameter int W    = 8,
    parameter int IDXW = 2,
    localparam int NREQ = 2 ** IDXW
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   op_sel,
    input  logic [NREQ*W-1:0] opa,
    input  logic [NREQ*W-1:0] opb,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      result,
    output logic              busy,
    output logic [IDXW-1:0]   owner
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state;
    logic [IDXW-1:0] rr_ptr;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic            op_r;

    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic [IDXW-1:0] cand;
    logic [W-1:0]    alu_val;

    function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scan rr_ptr, rr_ptr+1, ... ; the IDXW-bit add wraps modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_ptr + IDXW'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        alu_val = op_r ? (a_r * b_r) : (a_r + b_r);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= 1'b0;
            result <= '0;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner <= pick_idx;
                        a_r   <= opa[pick_idx*W +: W];
                        b_r   <= opb[pick_idx*W +: W];
                        op_r  <= op_sel[pick_idx];
                        state <= EXEC;
                        grant <= onehot(pick_idx);
                        busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    result <= alu_val;
                    state  <= DONE;
                    done   <= onehot(owner);
                end
                DONE: begin
                    // Just-served requester drops to lowest priority.
                    rr_ptr <= owner + IDXW'(1);
                    state  <= IDLE;
                    grant  <= '0;
                    done   <= '0;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    logic        clk;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  op_sel;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [7:0]  result;
    logic        busy;
    logic [1:0]  owner;

    int checks;
    int failures;

    alu_share_arbiter #(.W(8), .IDXW(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .op_sel (op_sel),
        .opa    (opa),
        .opb    (opb),
        .grant  (grant),
        .done   (done),
        .result (result),
        .busy   (busy),
        .owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output logic [3:0] d, output int cyc, output logic ok);
        ok  = 1'b0;
        d   = '0;
        cyc = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            cyc++;
            if (done != 4'b0000) begin
                ok = 1'b1;
                d  = done;
            end
        end
    endtask

    task automatic do_txn(input int i, input logic op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] res, output logic [3:0] d, output logic ok);
        int cyc;
        opa[i*8 +: 8] = a;
        opb[i*8 +: 8] = b;
        op_sel[i]     = op;
        req[i]        = 1'b1;
        wait_done(d, cyc, ok);
        res    = result;
        req[i] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) tick();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done: got %b expected 0000", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (result !== 8'h00) begin failures++; $display("FAIL reset_result: got %h expected 00", result); end
        checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        opa[7:0]  = 8'h12;
        opb[7:0]  = 8'h34;
        op_sel[0] = 1'b0;
        req       = 4'b0001;
        tick();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL t1_grant_exec: got %b expected 0001", grant); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy_exec: got %b expected 1", busy); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL t1_done_exec: got %b expected 0000", done); end
        tick();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL t1_grant_done: got %b expected 0001", grant); end
        checks++; if (done !== 4'b0001) begin failures++; $display("FAIL t1_done_pulse: got %b expected 0001", done); end
        checks++; if (result !== 8'h46) begin failures++; $display("FAIL t1_result: got %h expected 46", result); end
        req = 4'b0000;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_after: got %b expected 0", busy); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL t1_done_after: got %b expected 0000", done); end
        checks++; if (result !== 8'h46) begin failures++; $display("FAIL t1_result_hold: got %h expected 46", result); end
    endtask

    task automatic test_mul_trunc();
        logic [7:0] res;
        logic [3:0] d;
        logic       ok;
        do_txn(2, 1'b1, 8'h0F, 8'h11, res, d, ok);
        checks++; if (ok !== 1'b1 || d !== 4'b0100) begin failures++; $display("FAIL t2_mul_done: got %b expected 0100", d); end
        checks++; if (res !== 8'hFF) begin failures++; $display("FAIL t2_mul_ff: got %h expected ff", res); end
        checks++; if (owner !== 2'd2) begin failures++; $display("FAIL t2_owner: got %0d expected 2", owner); end
        do_txn(2, 1'b1, 8'h20, 8'h10, res, d, ok);
        checks++; if (ok !== 1'b1 || res !== 8'h00) begin failures++; $display("FAIL t2_mul_trunc: got %h expected 00", res); end
        do_txn(2, 1'b0, 8'hF0, 8'h20, res, d, ok);
        checks++; if (ok !== 1'b1 || res !== 8'h10) begin failures++; $display("FAIL t2_add_trunc: got %h expected 10", res); end
    endtask

    task automatic test_round_robin();
        logic [3:0] d;
        logic       ok;
        int         cyc;
        logic [7:0] exp_res [4];
        int         exp_idx [5];
        exp_res = '{8'h11, 8'h22, 8'h15, 8'h4C};
        exp_idx = '{0, 1, 2, 3, 0};
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        opa    = {8'h13, 8'h12, 8'h11, 8'h10};
        opb    = {8'h04, 8'h03, 8'h02, 8'h01};
        op_sel = 4'b1010;
        req    = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_done(d, cyc, ok);
            checks++; if (ok !== 1'b1) begin failures++; $display("FAIL t3_timeout[%0d]: got no done expected done", n); end
            checks++; if (d !== (4'b0001 << exp_idx[n])) begin failures++; $display("FAIL t3_order[%0d]: got %b expected %b", n, d, 4'b0001 << exp_idx[n]); end
            checks++; if (result !== exp_res[exp_idx[n]]) begin failures++; $display("FAIL t3_result[%0d]: got %h expected %h", n, result, exp_res[exp_idx[n]]); end
            checks++; if (cyc !== ((n == 0) ? 2 : 3)) begin failures++; $display("FAIL t3_spacing[%0d]: got %0d expected %0d", n, cyc, (n == 0) ? 2 : 3); end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_priority_after_serve();
        logic [7:0] res;
        logic [3:0] d;
        logic       ok;
        int         cyc;
        do_txn(1, 1'b0, 8'h01, 8'h01, res, d, ok);
        checks++; if (ok !== 1'b1 || res !== 8'h02) begin failures++; $display("FAIL t4_serve1: got %h expected 02", res); end
        opa[7:0]   = 8'h10; opb[7:0]   = 8'h20; op_sel[0] = 1'b0;
        opa[31:24] = 8'h01; opb[31:24] = 8'h02; op_sel[3] = 1'b0;
        req = 4'b1001;
        wait_done(d, cyc, ok);
        checks++; if (ok !== 1'b1 || d !== 4'b1000) begin failures++; $display("FAIL t4_first: got %b expected 1000", d); end
        checks++; if (result !== 8'h03) begin failures++; $display("FAIL t4_first_result: got %h expected 03", result); end
        req[3] = 1'b0;
        wait_done(d, cyc, ok);
        checks++; if (ok !== 1'b1 || d !== 4'b0001) begin failures++; $display("FAIL t4_second: got %b expected 0001", d); end
        checks++; if (result !== 8'h30) begin failures++; $display("FAIL t4_second_result: got %h expected 30", result); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_txn();
        logic [3:0] d;
        logic       ok;
        int         cyc;
        opa[23:16] = 8'h03; opb[23:16] = 8'h04; op_sel[2] = 1'b1;
        req = 4'b0100;
        tick();
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL t5_grant_exec: got %b expected 0100", grant); end
        resetn = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL t5_async_grant: got %b expected 0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t5_async_busy: got %b expected 0", busy); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL t5_async_done: got %b expected 0000", done); end
        checks++; if (result !== 8'h00) begin failures++; $display("FAIL t5_async_result: got %h expected 00", result); end
        tick();
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL t5_no_done: got %b expected 0000", done); end
        resetn = 1'b1;
        opa[7:0] = 8'h05; opb[7:0] = 8'h06; op_sel[0] = 1'b0;
        req = 4'b0101;
        tick();
        checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL t5_restart_grant: got %b expected 0001", grant); end
        wait_done(d, cyc, ok);
        checks++; if (ok !== 1'b1 || d !== 4'b0001 || result !== 8'h0B) begin failures++; $display("FAIL t5_req0: got done=%b result=%h expected done=0001 result=0b", d, result); end
        req[0] = 1'b0;
        wait_done(d, cyc, ok);
        checks++; if (ok !== 1'b1 || d !== 4'b0100 || result !== 8'h0C) begin failures++; $display("FAIL t5_req2: got done=%b result=%h expected done=0100 result=0c", d, result); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_operand_change();
        opa[15:8] = 8'h05; opb[15:8] = 8'h07; op_sel[1] = 1'b0;
        req = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL t6_grant: got %b expected 0010", grant); end
        req       = 4'b0000;
        opa[15:8] = 8'hAA;
        op_sel[1] = 1'b1;
        tick();
        checks++; if (done !== 4'b0010) begin failures++; $display("FAIL t6_done: got %b expected 0010", done); end
        checks++; if (result !== 8'h0C) begin failures++; $display("FAIL t6_latched: got %h expected 0c", result); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t6_idle: got %b expected 0", busy); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        req      = '0;
        op_sel   = '0;
        opa      = '0;
        opb      = '0;
        test_reset();
        test_single_add();
        test_mul_trunc();
        test_round_robin();
        test_priority_after_serve();
        test_reset_mid_txn();
        test_operand_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
